// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared definitions for the HI/LO execution unit: op_code encodings,
//   divider FSM state constants, the divide-by-zero result fill value
//   and small decode helpers.
package ex_muldiv_pkg;

  // Per-lane op_code encodings
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Divider FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A zero divisor makes every trial subtraction succeed, so the magnitude
  // quotient is filled with this bit and the remainder equals |dividend|.
  localparam logic DIVZERO_Q_BIT = 1'b1;

  // Ops that produce their HI/LO result in the issue cycle
  function automatic logic is_comb_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// ex_div_iter
//   Multi-cycle restoring divider with IDLE/RUN/DONE FSM.
//   Operands are converted to magnitudes on start, one quotient bit is
//   produced per RUN cycle, and sign correction is applied combinationally
//   on the outputs while in DONE.
//   Optional macro EX_MULDIV_DIVZERO_FAST_EN: a zero divisor skips RUN and
//   goes straight to DONE with the same result the full iteration gives.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           abort: back to IDLE next cycle
//   start           accept a divide (only honoured in IDLE)
//   is_signed       DIV (1) vs DIVU (0)
//   dividend/divisor raw operands
//   tag             issuing lane index, returned on done_tag
//   busy            state is not IDLE
//   done            state is DONE (result valid on quotient/remainder)
//   stall           issue group must be held this cycle
//   quotient/remainder sign-corrected result
module ex_div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [TAG_W-1:0]  tag,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [TAG_W-1:0]  done_tag,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef EX_MULDIV_DIVZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] quot_reg;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] dvsr_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic [TAG_W-1:0]  tag_reg;

  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   trial;
  logic              fits;

  assign abs_a = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
  assign abs_b = (is_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

  // One restoring step: bring the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not borrow.
  assign rem_shift = {rem_reg, quot_reg[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvsr_reg};
  assign fits      = ~trial[DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      tag_reg   <= '0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            neg_q_reg <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_r_reg <= is_signed & dividend[DATA_W-1];
            tag_reg   <= tag;
            dvsr_reg  <= abs_b;
            if (FAST_DZ && (abs_b == '0)) begin
              quot_reg  <= {DATA_W{DIVZERO_Q_BIT}};
              rem_reg   <= abs_a;
              count_reg <= '0;
              state_reg <= ST_DONE;
            end else begin
              quot_reg  <= abs_a;
              rem_reg   <= '0;
              count_reg <= CNT_W'(DATA_W);
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          quot_reg  <= {quot_reg[DATA_W-2:0], fits};
          rem_reg   <= fits ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
          count_reg <= count_reg - 1'b1;
          if (count_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The issue group is released this cycle; the DIV still on the
          // lanes is the same instruction and must not start again.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign stall     = ((state_reg == ST_IDLE) && start) || (state_reg == ST_RUN);
  assign done_tag  = tag_reg;
  assign quotient  = neg_q_reg ? -quot_reg : quot_reg;
  assign remainder = neg_r_reg ? -rem_reg  : rem_reg;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   HI/LO execution unit for an N-lane execute stage. MULT/MULTU/MTHI/MTLO
//   complete in the issue cycle; DIV/DIVU use the ex_div_iter sub-module.
//   All lane results are merged onto one HI/LO write port, the youngest
//   (highest-index) writing lane winning.
//   Optional macro EX_MULDIV_DIVZERO_FAST_EN (see ex_div_iter): zero
//   divisor completes one cycle after issue.
// Parameters:
//   DATA_W  operand / HI / LO width
//   LANES   issue lanes, lane 0 oldest
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             pipeline flush, aborts any divide, suppresses write
//   op_valid          per-lane op present
//   op_code           3 bits per lane
//   opa, opb          DATA_W bits per lane (rs, rt)
//   hi_i, lo_i        current forwarded HI/LO
//   hi_o, lo_o        write data (zero when whilo_o is low)
//   whilo_o           HI/LO write enable
//   stallreq          hold the issue group
//   div_busy          divider not IDLE
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        op_valid,
  input  logic [3*LANES-1:0]      op_code,
  input  logic [DATA_W*LANES-1:0] opa,
  input  logic [DATA_W*LANES-1:0] opb,
  input  logic [DATA_W-1:0]       hi_i,
  input  logic [DATA_W-1:0]       lo_i,
  output logic [DATA_W-1:0]       hi_o,
  output logic [DATA_W-1:0]       lo_o,
  output logic                    whilo_o,
  output logic                    stallreq,
  output logic                    div_busy
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [2:0]        lane_op [LANES];
  logic [DATA_W-1:0] lane_a  [LANES];
  logic [DATA_W-1:0] lane_b  [LANES];
  logic [DATA_W-1:0] lane_hi [LANES];
  logic [DATA_W-1:0] lane_lo [LANES];
  logic [LANES-1:0]  lane_wr;
  logic [LANES-1:0]  lane_div;

  // Per-lane decode and zero-latency results
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [2*DATA_W-1:0] prod;

    assign lane_op[gi] = op_code[3*gi +: 3];
    assign lane_a[gi]  = opa[DATA_W*gi +: DATA_W];
    assign lane_b[gi]  = opb[DATA_W*gi +: DATA_W];

    // Sign-extending to 2*DATA_W and keeping the low half of the product
    // gives the exact signed product without relying on signed operators.
    assign prod_s = {{DATA_W{lane_a[gi][DATA_W-1]}}, lane_a[gi]} *
                    {{DATA_W{lane_b[gi][DATA_W-1]}}, lane_b[gi]};
    assign prod_u = {{DATA_W{1'b0}}, lane_a[gi]} * {{DATA_W{1'b0}}, lane_b[gi]};
    assign prod   = (lane_op[gi] == OP_MULT) ? prod_s : prod_u;

    assign lane_hi[gi] = (lane_op[gi] == OP_MTHI) ? lane_a[gi] :
                         (lane_op[gi] == OP_MTLO) ? hi_i : prod[2*DATA_W-1:DATA_W];
    assign lane_lo[gi] = (lane_op[gi] == OP_MTLO) ? lane_a[gi] :
                         (lane_op[gi] == OP_MTHI) ? lo_i : prod[DATA_W-1:0];

    assign lane_wr[gi]  = op_valid[gi] & is_comb_op(lane_op[gi]);
    assign lane_div[gi] = op_valid[gi] & is_div_op(lane_op[gi]);
  end

  // Locate the (single) divide lane of the issue group
  logic              div_any;
  logic [LANE_W-1:0] div_lane;

  always_comb begin
    div_any  = 1'b0;
    div_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_div[i]) begin
        div_any  = 1'b1;
        div_lane = LANE_W'(i);
      end
    end
  end

  logic              div_start;
  logic              div_busy_int;
  logic              div_done;
  logic              div_stall;
  logic [LANE_W-1:0] done_tag;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;

  assign div_start = div_any & ~flush;

  ex_div_iter #(
    .DATA_W (DATA_W),
    .TAG_W  (LANE_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (div_start),
    .is_signed (lane_op[div_lane] == OP_DIV),
    .dividend  (lane_a[div_lane]),
    .divisor   (lane_b[div_lane]),
    .tag       (div_lane),
    .busy      (div_busy_int),
    .done      (div_done),
    .stall     (div_stall),
    .done_tag  (done_tag),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Program-order merge. Which lanes may write depends on the divider:
  //   DONE        : divide result, overridden by lanes younger than it
  //   RUN         : nothing (group held, older lanes already wrote)
  //   IDLE + DIV  : only lanes older than the divide (issue cycle)
  //   IDLE        : every lane
  logic              merge_wr;
  logic [DATA_W-1:0] merge_hi;
  logic [DATA_W-1:0] merge_lo;
  logic              lane_ok;

  always_comb begin
    merge_wr = 1'b0;
    merge_hi = '0;
    merge_lo = '0;
    lane_ok  = 1'b0;
    if (div_done) begin
      merge_wr = 1'b1;
      merge_hi = div_rem;
      merge_lo = div_quot;
    end
    for (int i = 0; i < LANES; i++) begin
      if (div_done) begin
        lane_ok = (i > int'(done_tag));
      end else if (div_busy_int) begin
        lane_ok = 1'b0;
      end else if (div_any) begin
        lane_ok = (i < int'(div_lane));
      end else begin
        lane_ok = 1'b1;
      end
      if (lane_wr[i] && lane_ok) begin
        merge_wr = 1'b1;
        merge_hi = lane_hi[i];
        merge_lo = lane_lo[i];
      end
    end
  end

  assign whilo_o  = merge_wr & ~flush & ~rst;
  assign hi_o     = whilo_o ? merge_hi : '0;
  assign lo_o     = whilo_o ? merge_lo : '0;
  assign stallreq = div_stall & ~flush & ~rst;
  assign div_busy = div_busy_int;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  localparam int W = 32;
  localparam int L = 2;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_MULT  = 3'd1;
  localparam logic [2:0] C_MULTU = 3'd2;
  localparam logic [2:0] C_DIV   = 3'd3;
  localparam logic [2:0] C_DIVU  = 3'd4;
  localparam logic [2:0] C_MTHI  = 3'd5;
  localparam logic [2:0] C_MTLO  = 3'd6;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [L-1:0]   op_valid;
  logic [3*L-1:0] op_code;
  logic [W*L-1:0] opa;
  logic [W*L-1:0] opb;
  logic [W-1:0]   hi_i, lo_i, hi_o, lo_o;
  logic           whilo_o, stallreq, div_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_W(W), .LANES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .op_valid (op_valid),
    .op_code  (op_code),
    .opa      (opa),
    .opb      (opb),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .whilo_o  (whilo_o),
    .stallreq (stallreq),
    .div_busy (div_busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid[l]      = (c != C_NONE);
    op_code[3*l +: 3] = c;
    opa[W*l +: W]     = a;
    opb[W*l +: W]     = b;
  endtask

  // ---- reference model: arithmetic straight from the op definitions ----
  function automatic void lane_ref(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] hi, input logic [W-1:0] lo,
                                   output bit ok, output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint      ps;
    logic [63:0] pu;
    ok = 1'b1; rh = '0; rl = '0;
    case (c)
      C_MULT:  begin ps = longint'($signed(a)) * longint'($signed(b)); rh = ps[63:32]; rl = ps[31:0]; end
      C_MULTU: begin pu = {32'd0, a} * {32'd0, b}; rh = pu[63:32]; rl = pu[31:0]; end
      C_MTHI:  begin rh = a;  rl = lo; end
      C_MTLO:  begin rh = hi; rl = a;  end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void div_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    bit          sa, sb;
    logic [W-1:0] ma, mb;
    sa = sgn && a[W-1];
    sb = sgn && b[W-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    if (mb == 0) begin q = '1; r = ma; end
    else begin q = ma / mb; r = ma % mb; end
    if (sa != sb) q = -q;
    if (sa) r = -r;
  endfunction

  // ---- one full divide transaction with the other lane carrying oc ----
  task automatic run_div(input int dl, input logic [2:0] dc, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] oc, input logic [W-1:0] oa,
                         input logic [W-1:0] hi, input logic [W-1:0] lo);
    int ol, cyc, exp_lat;
    bit bad, ok;
    logic [W-1:0] eh, el, q, r;
    ol = 1 - dl;
    @(posedge clk); #1;
    flush = 1'b0; hi_i = hi; lo_i = lo;
    set_lane(dl, dc, a, b);
    set_lane(ol, oc, oa, b);
    @(negedge clk);
    lane_ref(oc, oa, b, hi, lo, ok, eh, el);
    check("issue_stall", {31'd0, stallreq}, 1);
    check("issue_busy",  {31'd0, div_busy}, 0);
    if (ol < dl && ok) begin
      check("issue_whilo", {31'd0, whilo_o}, 1);
      check("issue_hi", hi_o, eh);
      check("issue_lo", lo_o, el);
    end else begin
      check("issue_whilo", {31'd0, whilo_o}, 0);
    end
    cyc = 0; bad = 1'b0;
    while (cyc < W + 8) begin
      @(negedge clk);
      cyc++;
      if (!stallreq) break;
      if (whilo_o || !div_busy) bad = 1'b1;
    end
`ifdef EX_MULDIV_DIVZERO_FAST_EN
    exp_lat = (b == 0 || (dc == C_DIV && -b == 0)) ? 1 : W + 1;
`else
    exp_lat = W + 1;
`endif
    check("div_latency", cyc, exp_lat);
    check("run_quiet", {31'd0, bad}, 0);
    div_ref(dc == C_DIV, a, b, q, r);
    eh = r; el = q;
    if (ol > dl && ok) lane_ref(oc, oa, b, hi, lo, ok, eh, el);
    check("done_whilo", {31'd0, whilo_o}, 1);
    check("done_hi", hi_o, eh);
    check("done_lo", lo_o, el);
    $display("[TB] div lane%0d op%0d a=%08h b=%08h other op%0d -> hi=%08h lo=%08h after %0d cycles",
             dl, dc, a, b, oc, hi_o, lo_o, cyc);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    set_lane(0, C_NONE, '0, '0);
    set_lane(1, C_NONE, '0, '0);
    @(negedge clk);
    check({tag, "_busy"},  {31'd0, div_busy}, 0);
    check({tag, "_stall"}, {31'd0, stallreq}, 0);
    check({tag, "_whilo"}, {31'd0, whilo_o}, 0);
  endtask

  typedef struct {
    logic [2:0]   c0, c1;
    logic [W-1:0] a0, b0, a1, b1, hi, lo;
    logic         ew;
    logic [W-1:0] eh, el;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  logic [2:0] comb_ops [5];

  initial begin
    comb_ops[0] = C_NONE; comb_ops[1] = C_MULT; comb_ops[2] = C_MULTU;
    comb_ops[3] = C_MTHI; comb_ops[4] = C_MTLO;

    vecs[0] = '{C_MULT,  C_NONE, 32'hFFFFFFFE, 32'h3, 0, 0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{C_MTHI,  C_MTLO, 32'h11, 0, 32'h22, 0, 32'hA, 32'hB, 1'b1, 32'hA, 32'h22};
    vecs[2] = '{C_MULTU, C_NONE, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vecs[3] = '{C_NONE,  C_NONE, 32'h5, 32'h6, 32'h7, 32'h8, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{C_MTLO,  C_MULT, 32'h5, 0, 32'h80000000, 32'h80000000, 0, 0, 1'b1, 32'h40000000, 32'h0};
    vecs[5] = '{C_MULT,  C_MTHI, 32'h7, 32'h9, 32'h1234, 0, 32'h55, 32'h99, 1'b1, 32'h1234, 32'h99};

    rst = 1'b1; flush = 1'b0; hi_i = '0; lo_i = '0;
    op_valid = '0; op_code = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_whilo", {31'd0, whilo_o}, 0);
    check("rst_stall", {31'd0, stallreq}, 0);
    check("rst_busy",  {31'd0, div_busy}, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      hi_i = vecs[i].hi; lo_i = vecs[i].lo;
      set_lane(0, vecs[i].c0, vecs[i].a0, vecs[i].b0);
      set_lane(1, vecs[i].c1, vecs[i].a1, vecs[i].b1);
      @(negedge clk);
      check($sformatf("vec%0d_whilo", i), {31'd0, whilo_o}, {31'd0, vecs[i].ew});
      check($sformatf("vec%0d_hi", i), hi_o, vecs[i].eh);
      check($sformatf("vec%0d_lo", i), lo_o, vecs[i].el);
      check($sformatf("vec%0d_stall", i), {31'd0, stallreq}, 0);
      $display("[TB] vec %0d: whilo=%0b hi=%08h lo=%08h", i, whilo_o, hi_o, lo_o);
    end

    // ---- random zero-latency groups ----
    for (int i = 0; i < 20; i++) begin
      logic [2:0]   c [2];
      logic [W-1:0] a [2], b [2];
      logic [W-1:0] eh, el, th, tl;
      bit ew, ok;
      @(posedge clk); #1;
      hi_i = $urandom; lo_i = $urandom;
      ew = 1'b0; eh = '0; el = '0;
      for (int l = 0; l < 2; l++) begin
        c[l] = comb_ops[$urandom_range(0, 4)];
        a[l] = $urandom; b[l] = $urandom;
        set_lane(l, c[l], a[l], b[l]);
        lane_ref(c[l], a[l], b[l], hi_i, lo_i, ok, th, tl);
        if (ok) begin ew = 1'b1; eh = th; el = tl; end
      end
      @(negedge clk);
      check("rnd_whilo", {31'd0, whilo_o}, {31'd0, ew});
      check("rnd_hi", hi_o, eh);
      check("rnd_lo", lo_o, el);
      check("rnd_stall", {31'd0, stallreq}, 0);
      $display("[TB] rnd %0d: ops %0d/%0d hi=%08h lo=%08h", i, c[0], c[1], hi_o, lo_o);
    end

    // ---- directed divides ----
    run_div(0, C_DIV, 32'hFFFFFFF9, 32'h2, C_NONE, '0, 32'h1, 32'h2);
    idle_check("after_done");
    run_div(1, C_DIVU, 32'd100, 32'd7, C_MTLO, 32'd5, 32'hA, 32'hB);
    run_div(0, C_DIVU, 32'd5, 32'd0, C_NONE, '0, 0, 0);       // back-to-back with the previous
    run_div(0, C_DIV, 32'hFFFFFFFB, 32'd0, C_MTHI, 32'h77, 0, 0);
    run_div(1, C_DIV, 32'h80000000, 32'hFFFFFFFF, C_MULT, 32'h3, 0, 0);
    idle_check("b2b_end");

    // ---- flush at t+10, new DIV at t+11 ----
    @(posedge clk); #1;
    set_lane(0, C_DIV, 32'd1000, 32'd3);
    set_lane(1, C_NONE, '0, '0);
    @(negedge clk);
    check("fl_issue_stall", {31'd0, stallreq}, 1);
    repeat (9) @(negedge clk);
    check("fl_t9_stall", {31'd0, stallreq}, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("fl_stall", {31'd0, stallreq}, 0);
    check("fl_whilo", {31'd0, whilo_o}, 0);
    run_div(0, C_DIV, 32'hFFFFFC18, 32'd3, C_NONE, '0, 0, 0);
    $display("[TB] flush sequence done");

    // ---- reset mid-RUN ----
    @(posedge clk); #1;
    set_lane(0, C_NONE, '0, '0);
    set_lane(1, C_DIVU, 32'd77, 32'd5);
    @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rstrun_stall", {31'd0, stallreq}, 0);
    check("rstrun_whilo", {31'd0, whilo_o}, 0);
    @(posedge clk); #1 rst = 1'b0;
    set_lane(1, C_NONE, '0, '0);
    @(negedge clk);
    check("rstrun_busy", {31'd0, div_busy}, 0);
    $display("[TB] reset-in-run sequence done");

    // ---- random divides ----
    for (int i = 0; i < 12; i++) begin
      int           dl;
      logic [2:0]   dc, oc;
      logic [W-1:0] a, b;
      dl = $urandom_range(0, 1);
      dc = ($urandom_range(0, 1) == 1) ? C_DIV : C_DIVU;
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        2:       b = -W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      oc = comb_ops[$urandom_range(0, 4)];
      run_div(dl, dc, a, b, oc, $urandom, $urandom, $urandom);
    end
    idle_check("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

- Parametrised HI/LO execution unit for the N-lane execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from any issue lane.
- Multiply and move ops complete combinationally; DIV/DIVU run a multi-cycle restoring divider.
- Merges all lanes' HI/LO writes into one per-cycle write port with program-order priority, and drives the stall request the pipeline controller uses to hold the issue group.

## Interface
Parameters:
- DATA_W, 32, operand/HI/LO width (≥8, even)
- LANES, 2, issue lanes; lane 0 is oldest in program order

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush/exception; aborts any divide
- op_valid  in  LANES  lane carries a HI/LO op (already annulled by exceptions)
- op_code  in  3*LANES  per lane: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- opa  in  DATA_W*LANES  per-lane rs value
- opb  in  DATA_W*LANES  per-lane rt value
- hi_i, lo_i  in  DATA_W  current architectural HI/LO, already forwarded
- hi_o, lo_o  out  DATA_W  write data
- whilo_o  out  1  HI/LO write enable
- stallreq  out  1  hold the issue group
- div_busy  out  1  divider not IDLE

## Operation
- Decode guarantees at most one DIV/DIVU per issue group; the other op codes may appear in several lanes.
- Lane results:
  - MULT/MULTU: {hi,lo} = signed/unsigned 2*DATA_W product.
  - MTHI: hi = opa, lo = lo_i.
  - MTLO: lo = opa, hi = hi_i.
  - DIV: lo = quotient, hi = remainder.
- Write merge: the highest-index valid lane with a completed result wins both hi_o and lo_o. Later program order overrides earlier.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE: a valid DIV/DIVU with no flush latches |opa|, |opb|, the result signs, and the lane index. Clear the remainder, set count = DATA_W, go to RUN. stallreq = 1.
  - RUN: one restoring step per cycle (shift remainder, trial-subtract, set one quotient bit); count decrements. When count reaches 1 the step completes and the FSM goes to DONE. stallreq = 1.
  - DONE: apply sign correction. Quotient is negated if the signs differ (signed). Remainder takes the dividend's sign. Drive the divide lane's result into the merge and set stallreq = 0. Go to IDLE unconditionally; the still-presented DIV is not restarted.
- While the divider is in IDLE/RUN, lanes younger than the divide lane are blocked and do not write. Lanes older than it write normally only in the issue cycle.
  - Net effect: in DONE, lanes above the divide lane merge; lanes below do not rewrite.
- Divide by zero gives the result the full iteration produces: unsigned Q = all-ones, R = dividend, then normal sign correction.
- flush in any state: go to IDLE, whilo_o = 0, stallreq = 0 that cycle. Flush takes priority over a new DIV.
- Reset values: state IDLE, count 0, whilo_o 0, hi_o 0, lo_o 0, stallreq 0, div_busy 0.

## Timing
- MULT/MULTU/MTHI/MTLO: whilo_o in the same cycle, zero latency, no stall.
- DIV issued at cycle t:
  - stallreq is high for cycles t .. t+DATA_W.
  - DONE is at t+DATA_W+1, with whilo_o = 1 and stallreq = 0.
  - Total hold is DATA_W+1 cycles.
- Back-to-back DIVs: the second is accepted from IDLE at the cycle after DONE.
- rst or flush mid-RUN: idle from the next cycle, with no write.

## Configuration
- EX_MULDIV_DIVZERO_FAST_EN defined: a zero divisor is detected in IDLE and the FSM goes directly to DONE at t+1, with results identical to full iteration. stallreq is high only in cycle t.
- Undefined: a zero divisor takes the full DATA_W+1 cycles.

## Structure
- Shared package:
  - op_code encodings
  - FSM state enum
  - DIVZERO result helper constants
- One sub-module: ex_div_iter (the FSM plus restoring datapath, with start/flush/done handshake).
- Lane decode and priority merge stay in the top.

## Test plan
- Lane0 MULT 0xFFFFFFFE × 0x00000003, lane1 NONE → same cycle: whilo_o = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, stallreq = 0.
- Lane0 MTHI 0x11, lane1 MTLO 0x22, with hi_i = 0xA, lo_i = 0xB → lane1 wins: hi = 0xA, lo = 0x22.
- Lane0 DIV -7 / 2 → stallreq high for 33 cycles; DONE gives lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; the cycle after DONE is IDLE.
- Lane1 DIVU 100 / 7, lane0 MTLO 5 → lo_i path written in cycle t. At DONE: lo = 14, hi = 2; lane0 does not rewrite.
- DIVU 5 / 0 → hi = 5, lo = 0xFFFFFFFF. Completion is at t+1 with the macro and at t+33 without it.
- DIV with flush at t+10 → state IDLE, no whilo_o, stallreq low at t+10. A DIV issued at t+11 completes correctly.
